// File: rtl/iq_mixer_nco_if.sv
// ADC-side sample/control inputs and prefilter-side results of iq_mixer_nco.
// The slave modport faces the mixer; the master modport faces the ADC/prefilter side.
interface iq_mixer_nco_if #(
  parameter int IN_W    = 4,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
);
  logic                      i_adc_eoc;
  logic        [IN_W-1:0]    i_I_if;
  logic        [IN_W-1:0]    i_Q_if;
  logic        [PHASE_W-1:0] i_phase_inc;
  logic                      i_phase_clr;
  logic        [1:0]         i_mode;
  logic signed [OUT_W-1:0]   o_I_prefilter;
  logic signed [OUT_W-1:0]   o_Q_prefilter;
  logic                      o_sample_ready;
  logic                      o_sat;

  modport master (
    output i_adc_eoc, i_I_if, i_Q_if, i_phase_inc, i_phase_clr, i_mode,
    input  o_I_prefilter, o_Q_prefilter, o_sample_ready, o_sat
  );

  modport slave (
    input  i_adc_eoc, i_I_if, i_Q_if, i_phase_inc, i_phase_clr, i_mode,
    output o_I_prefilter, o_Q_prefilter, o_sample_ready, o_sat
  );
endinterface

// File: rtl/iq_mixer_nco.sv
// Complex IF-to-baseband mixer with per-sample NCO; result registered 4 clocks after eoc is first sampled high.
// No backpressure: one result per capture, never stalls.
module iq_mixer_nco #(
  parameter int IN_W    = 4,
  parameter int LO_W    = 4,
  parameter int LUT_AW  = 4,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  iq_mixer_nco_if.slave bus
);
  localparam int  LUT_N  = 1 << LUT_AW;
  localparam int  PW     = IN_W + LO_W;
  localparam int  SW     = PW + 1;
  localparam real AMP    = real'((1 << (LO_W - 1)) - 1);
  localparam real TWO_PI = 6.283185307179586;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [LO_W-1:0] cos_lut [LUT_N];
  logic signed [LO_W-1:0] sin_lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam int COS_V = int'(AMP * $cos(TWO_PI * k / LUT_N));
    localparam int SIN_V = int'(AMP * $sin(TWO_PI * k / LUT_N));
    assign cos_lut[k] = COS_V[LO_W-1:0];
    assign sin_lut[k] = SIN_V[LO_W-1:0];
  end

  // Sync flops reset high so an eoc already high at reset release is not a capture.
  logic s1, s2, s3, cap;
  always_ff @(posedge i_clk) begin
    if (i_rst) {s1, s2, s3} <= 3'b111;
    else       {s1, s2, s3} <= {bus.i_adc_eoc, s1, s2};
  end
  assign cap = s2 & ~s3;

  logic [PHASE_W-1:0]     phase, phase_use;
  logic [LUT_AW-1:0]      lut_idx;
  logic                   cap_vld;
  logic signed [IN_W-1:0] x_i, x_q;
  logic signed [LO_W-1:0] lo_cos, lo_sin;
  logic [1:0]             cap_mode;

  assign phase_use = bus.i_phase_clr ? '0 : phase;
  assign lut_idx   = phase_use[PHASE_W-1 -: LUT_AW];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase   <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= cap;
      if (cap)                  phase <= phase_use + bus.i_phase_inc;
      else if (bus.i_phase_clr) phase <= '0;
    end
  end

  // Offset-binary to two's complement is an MSB flip.
  always_ff @(posedge i_clk) begin
    if (cap) begin
      x_i      <= bus.i_I_if ^ {1'b1, {(IN_W - 1){1'b0}}};
      x_q      <= bus.i_Q_if ^ {1'b1, {(IN_W - 1){1'b0}}};
      lo_cos   <= cos_lut[lut_idx];
      lo_sin   <= sin_lut[lut_idx];
      cap_mode <= bus.i_mode;
    end
  end

  logic signed [PW-1:0]   xi_w, xq_w, c_w, s_w;
  logic signed [PW-1:0]   p_ic, p_is, p_qc, p_qs;
  logic signed [IN_W-1:0] d_i, d_q;
  logic [1:0]             prod_mode;
  logic                   prod_vld;

  assign xi_w = PW'(x_i);
  assign xq_w = PW'(x_q);
  assign c_w  = PW'(lo_cos);
  assign s_w  = PW'(lo_sin);

  always_ff @(posedge i_clk) begin
    if (i_rst) prod_vld <= 1'b0;
    else       prod_vld <= cap_vld;
  end

  always_ff @(posedge i_clk) begin
    if (cap_vld) begin
      p_ic      <= xi_w * c_w;
      p_is      <= xi_w * s_w;
      p_qc      <= xq_w * c_w;
      p_qs      <= xq_w * s_w;
      d_i       <= x_i;
      d_q       <= x_q;
      prod_mode <= cap_mode;
    end
  end

  logic signed [SW-1:0] sum_i, sum_q;
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    if (prod_mode[1]) begin
      sum_i = SW'(d_i);
      sum_q = SW'(d_q);
    end else if (!prod_mode[0]) begin
      sum_i = SW'(p_ic) - SW'(p_qs);
      sum_q = SW'(p_is) + SW'(p_qc);
    end else begin
      sum_i = SW'(p_ic) + SW'(p_qs);
      sum_q = SW'(p_qc) - SW'(p_is);
    end
  end

  // Returns {clip_flag, saturated_value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return {1'b1, SAT_MAX[OUT_W-1:0]};
    if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] sat_i, sat_q;
  assign sat_i = saturate(sum_i);
  assign sat_q = saturate(sum_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_I_prefilter  <= '0;
      bus.o_Q_prefilter  <= '0;
      bus.o_sample_ready <= 1'b0;
      bus.o_sat          <= 1'b0;
    end else begin
      bus.o_sample_ready <= prod_vld;
      if (prod_vld) begin
        bus.o_I_prefilter <= sat_i[OUT_W-1:0];
        bus.o_Q_prefilter <= sat_q[OUT_W-1:0];
        bus.o_sat         <= sat_i[OUT_W] | sat_q[OUT_W];
      end
    end
  end
endmodule

// File: tb/tb_iq_mixer_nco.sv
// Scoreboard bench: directed vectors push expected results; a negedge monitor pops and compares
// an 8-bit-output and a 6-bit-output mixer driven with identical stimulus.
module tb_iq_mixer_nco;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  iq_mixer_nco_if #(.IN_W(4), .PHASE_W(8), .OUT_W(8)) b8 ();
  iq_mixer_nco_if #(.IN_W(4), .PHASE_W(8), .OUT_W(6)) b6 ();

  iq_mixer_nco #(.OUT_W(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(b8));
  iq_mixer_nco #(.OUT_W(6)) dut6 (.i_clk(clk), .i_rst(rst), .bus(b6));

  assign b6.i_adc_eoc   = b8.i_adc_eoc;
  assign b6.i_I_if      = b8.i_I_if;
  assign b6.i_Q_if      = b8.i_Q_if;
  assign b6.i_phase_inc = b8.i_phase_inc;
  assign b6.i_phase_clr = b8.i_phase_clr;
  assign b6.i_mode      = b8.i_mode;

  typedef struct {
    int i8; int q8; int s8;
    int i6; int q6; int s6;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_miss = 0, n_app = 0, rdy_seen = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (b8.o_sample_ready || b6.o_sample_ready) begin
      rdy_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("rdy8", int'(b8.o_sample_ready), 1);
        chk("rdy6", int'(b6.o_sample_ready), 1);
        chk("I8", b8.o_I_prefilter, e.i8);
        chk("Q8", b8.o_Q_prefilter, e.q8);
        chk("sat8", int'(b8.o_sat), e.s8);
        chk("I6", b6.o_I_prefilter, e.i6);
        chk("Q6", b6.o_Q_prefilter, e.q6);
        chk("sat6", int'(b6.o_sat), e.s6);
      end
    end
  end

  // Raise eoc on a negedge; E0 is the next posedge, result visible at the negedge after E4.
  task automatic apply(input logic [3:0] i_v, input logic [3:0] q_v, input logic [7:0] inc,
                       input logic [1:0] mode, input logic clr,
                       input int i8, input int q8, input int s8,
                       input int i6, input int q6, input int s6);
    exp_t e;
    @(negedge clk);
    b8.i_I_if      = i_v;
    b8.i_Q_if      = q_v;
    b8.i_phase_inc = inc;
    b8.i_mode      = mode;
    b8.i_adc_eoc   = 1'b1;
    e = '{i8: i8, q8: q8, s8: s8, i6: i6, q6: q6, s6: s6, cyc: cyc + 5};
    exp_q.push_back(e);
    n_app++;
    @(negedge clk);
    @(negedge clk);
    b8.i_phase_clr = clr;
    @(negedge clk);
    b8.i_phase_clr = 1'b0;
    b8.i_adc_eoc   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int base;
    rst            = 1'b1;
    b8.i_adc_eoc   = 1'b1;
    b8.i_I_if      = 4'h0;
    b8.i_Q_if      = 4'h0;
    b8.i_phase_inc = 8'd0;
    b8.i_phase_clr = 1'b0;
    b8.i_mode      = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_ready", rdy_seen, 0);
    chk("rst_I8", b8.o_I_prefilter, 0);
    chk("rst_Q8", b8.o_Q_prefilter, 0);
    chk("rst_sat8", int'(b8.o_sat), 0);
    chk("rst_I6", b6.o_I_prefilter, 0);
    b8.i_adc_eoc = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while a sample is in flight: it must never emerge.
    base = rdy_seen;
    @(negedge clk);
    b8.i_I_if    = 4'hF;
    b8.i_Q_if    = 4'h8;
    b8.i_adc_eoc = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    b8.i_adc_eoc = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_ready", rdy_seen - base, 0);

    //     I     Q     inc    mode   clr   I8   Q8  s8   I6   Q6  s6
    apply(4'hF, 4'h8, 8'd0,   2'b00, 1'b0,  49,   0, 0,  31,   0, 1);
    apply(4'h0, 4'h0, 8'd0,   2'b00, 1'b0, -56, -56, 0, -32, -32, 1);
    apply(4'hF, 4'h8, 8'd64,  2'b00, 1'b0,  49,   0, 0,  31,   0, 1);
    apply(4'hF, 4'h8, 8'd64,  2'b00, 1'b0,   0,  49, 0,   0,  31, 1);
    apply(4'hF, 4'h8, 8'd64,  2'b01, 1'b1,  49,   0, 0,  31,   0, 1);
    apply(4'hF, 4'h8, 8'd64,  2'b01, 1'b0,   0, -49, 0,   0, -32, 1);
    @(negedge clk);
    b8.i_phase_clr = 1'b1;
    @(negedge clk);
    b8.i_phase_clr = 1'b0;
    apply(4'hF, 4'h8, 8'd0,   2'b00, 1'b0,  49,   0, 0,  31,   0, 1);
    apply(4'hA, 4'h5, 8'd0,   2'b10, 1'b0,   2,  -3, 0,   2,  -3, 0);
    apply(4'h0, 4'hF, 8'd0,   2'b11, 1'b0,  -8,   7, 0,  -8,   7, 0);
    apply(4'hF, 4'h8, 8'd128, 2'b00, 1'b0,  49,   0, 0,  31,   0, 1);
    apply(4'hC, 4'h6, 8'd160, 2'b00, 1'b0, -28,  14, 0, -28,  14, 0);
    apply(4'hB, 4'h9, 8'd0,   2'b00, 1'b0,  10,  20, 0,  10,  20, 0);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    chk("ready_pulses", rdy_seen, n_app);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
